brq_rf_wb_arbiter: RTL and testbench

BRQ_RF_WB_ARBITER -- requirements
Module: brq_rf_wb_arbiter

---
 rtl/brq_pkg.sv | 25 ++
 rtl/brq_rf_wb_arbiter_if.sv | 44 ++++
 rtl/brq_rf_scoreboard.sv | 42 ++++
 rtl/brq_rf_wb_arbiter.sv | 94 +++++++++
 tb/tb_brq_rf_wb_arbiter.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/brq_pkg.sv
// Shared types for the register-file writeback path: request struct,
// requester index and the legal-destination check.
package brq_pkg;

    localparam int unsigned AddrWidth    = 5;
    localparam int unsigned NumRegsMax   = 32;
    localparam int unsigned MaxDataWidth = 64;

    typedef enum logic {
        WB_MAIN = 1'b0,
        WB_LONG = 1'b1
    } wb_idx_e;

    typedef struct packed {
        logic                    valid;
        logic [AddrWidth-1:0]    waddr;
        logic [MaxDataWidth-1:0] wdata;
    } wb_req_t;

    // x0 is hardwired; under RV32E only x0..x15 exist.
    function automatic logic reg_legal(input logic [AddrWidth-1:0] addr, input logic rv32e);
        return (addr != '0) && !(rv32e && addr[AddrWidth-1]);
    endfunction

endpackage

// File: rtl/brq_rf_wb_arbiter_if.sv
// Writeback arbiter bus: issue tracking, two writeback requesters,
// register-file write port and hazard lookups.
interface brq_rf_wb_arbiter_if #(
    parameter int unsigned DataWidth = 32
);
    logic                 issue_valid_i;
    logic [4:0]           issue_waddr_i;
    logic                 req0_valid_i;
    logic                 req0_ready_o;
    logic [4:0]           req0_waddr_i;
    logic [DataWidth-1:0] req0_wdata_i;
    logic                 req1_valid_i;
    logic                 req1_ready_o;
    logic [4:0]           req1_waddr_i;
    logic [DataWidth-1:0] req1_wdata_i;
    logic                 rf_we_o;
    logic [4:0]           rf_waddr_o;
    logic [DataWidth-1:0] rf_wdata_o;
    logic [4:0]           raddr_a_i;
    logic [4:0]           raddr_b_i;
    logic                 hazard_a_o;
    logic                 hazard_b_o;
    logic                 busy_o;

    modport master (
        output issue_valid_i, issue_waddr_i,
        output req0_valid_i, req0_waddr_i, req0_wdata_i,
        output req1_valid_i, req1_waddr_i, req1_wdata_i,
        output raddr_a_i, raddr_b_i,
        input  req0_ready_o, req1_ready_o,
        input  rf_we_o, rf_waddr_o, rf_wdata_o,
        input  hazard_a_o, hazard_b_o, busy_o
    );

    modport slave (
        input  issue_valid_i, issue_waddr_i,
        input  req0_valid_i, req0_waddr_i, req0_wdata_i,
        input  req1_valid_i, req1_waddr_i, req1_wdata_i,
        input  raddr_a_i, raddr_b_i,
        output req0_ready_o, req1_ready_o,
        output rf_we_o, rf_waddr_o, rf_wdata_o,
        output hazard_a_o, hazard_b_o, busy_o
    );
endinterface

// File: rtl/brq_rf_scoreboard.sv
// Per-register pending-write scoreboard: set on issue, clear on commit,
// two combinational lookups and an any-pending flag.
module brq_rf_scoreboard
    import brq_pkg::*;
#(
    parameter bit RV32E = 1'b0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 set_valid_i,
    input  logic [AddrWidth-1:0] set_addr_i,
    input  logic                 clr_valid_i,
    input  logic [AddrWidth-1:0] clr_addr_i,
    input  logic [AddrWidth-1:0] lookup_a_addr_i,
    input  logic [AddrWidth-1:0] lookup_b_addr_i,
    output logic                 lookup_a_o,
    output logic                 lookup_b_o,
    output logic                 busy_o
);

    logic [NumRegsMax-1:0] pending_q, pending_d;
    logic [NumRegsMax-1:0] set_mask, clr_mask;

    // Set is applied after clear so a same-cycle re-issue keeps the bit.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_valid_i && reg_legal(set_addr_i, RV32E)) set_mask[set_addr_i] = 1'b1;
        if (clr_valid_i && reg_legal(clr_addr_i, RV32E)) clr_mask[clr_addr_i] = 1'b1;
        pending_d = (pending_q & ~clr_mask) | set_mask;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) pending_q <= '0;
        else         pending_q <= pending_d;
    end

    assign lookup_a_o = reg_legal(lookup_a_addr_i, RV32E) && pending_q[lookup_a_addr_i];
    assign lookup_b_o = reg_legal(lookup_b_addr_i, RV32E) && pending_q[lookup_b_addr_i];
    assign busy_o     = |pending_q;

endmodule

// File: rtl/brq_rf_wb_arbiter.sv
// Round-robin arbiter between main-pipeline and long-latency writeback,
// registered register-file write port and pending-write scoreboard.
module brq_rf_wb_arbiter
    import brq_pkg::*;
#(
    parameter bit          RV32E     = 1'b0,
    parameter int unsigned DataWidth = 32
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    brq_rf_wb_arbiter_if.slave  bus
);

    wb_req_t [1:0]        req;
    wb_idx_e              last_q, last_d;
    wb_idx_e              sel;
    logic                 gnt_main, gnt_long, xfer, xfer_legal;
    logic                 rf_we_q, rf_we_d;
    logic [AddrWidth-1:0] rf_waddr_q, rf_waddr_d;
    logic [DataWidth-1:0] rf_wdata_q, rf_wdata_d;
    logic                 unused_wdata;

    always_comb begin
        req                            = '0;
        req[WB_MAIN].valid             = bus.req0_valid_i;
        req[WB_MAIN].waddr             = bus.req0_waddr_i;
        req[WB_MAIN].wdata[DataWidth-1:0] = bus.req0_wdata_i;
        req[WB_LONG].valid             = bus.req1_valid_i;
        req[WB_LONG].waddr             = bus.req1_waddr_i;
        req[WB_LONG].wdata[DataWidth-1:0] = bus.req1_wdata_i;
    end

    assign unused_wdata = ^{req[WB_MAIN].wdata, req[WB_LONG].wdata};

    // Under contention the requester not granted last time wins.
    assign gnt_main   = req[WB_MAIN].valid && (!req[WB_LONG].valid || last_q == WB_LONG);
    assign gnt_long   = req[WB_LONG].valid && !gnt_main;
    assign sel        = gnt_long ? WB_LONG : WB_MAIN;
    assign xfer       = gnt_main || gnt_long;
    assign xfer_legal = xfer && reg_legal(req[sel].waddr, RV32E);

    assign bus.req0_ready_o = gnt_main;
    assign bus.req1_ready_o = gnt_long;

    // Writes to x0 or nonexistent RV32E registers are consumed silently
    // and leave the write-port address/data untouched.
    always_comb begin
        last_d     = xfer ? sel : last_q;
        rf_we_d    = xfer_legal;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (xfer_legal) begin
            rf_waddr_d = req[sel].waddr;
            rf_wdata_d = req[sel].wdata[DataWidth-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q     <= WB_LONG;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            last_q     <= last_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign bus.rf_we_o    = rf_we_q;
    assign bus.rf_waddr_o = rf_waddr_q;
    assign bus.rf_wdata_o = rf_wdata_q;

    // Clearing on the committing edge keeps the hazard up through the
    // rf_we_o cycle, so readers only proceed once the RF holds the value.
    brq_rf_scoreboard #(
        .RV32E (RV32E)
    ) u_scoreboard (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .set_valid_i     (bus.issue_valid_i),
        .set_addr_i      (bus.issue_waddr_i),
        .clr_valid_i     (rf_we_q),
        .clr_addr_i      (rf_waddr_q),
        .lookup_a_addr_i (bus.raddr_a_i),
        .lookup_b_addr_i (bus.raddr_b_i),
        .lookup_a_o      (bus.hazard_a_o),
        .lookup_b_o      (bus.hazard_b_o),
        .busy_o          (bus.busy_o)
    );

endmodule

// File: tb/tb_brq_rf_wb_arbiter.sv
// Directed bench for the writeback arbiter: one RV32I and one RV32E instance.
module tb_brq_rf_wb_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_mis = 0;

    always #5 clk = ~clk;

    brq_rf_wb_arbiter_if #(.DataWidth(32)) bus   ();
    brq_rf_wb_arbiter_if #(.DataWidth(32)) bus_e ();

    brq_rf_wb_arbiter #(.RV32E(1'b0), .DataWidth(32)) dut (
        .clk_i (clk), .rst_ni (rst_n), .bus (bus)
    );
    brq_rf_wb_arbiter #(.RV32E(1'b1), .DataWidth(32)) dut_e (
        .clk_i (clk), .rst_ni (rst_n), .bus (bus_e)
    );

    task automatic idle();
        bus.issue_valid_i = 0; bus.issue_waddr_i = 0;
        bus.req0_valid_i = 0; bus.req0_waddr_i = 0; bus.req0_wdata_i = 0;
        bus.req1_valid_i = 0; bus.req1_waddr_i = 0; bus.req1_wdata_i = 0;
        bus.raddr_a_i = 0; bus.raddr_b_i = 0;
        bus_e.issue_valid_i = 0; bus_e.issue_waddr_i = 0;
        bus_e.req0_valid_i = 0; bus_e.req0_waddr_i = 0; bus_e.req0_wdata_i = 0;
        bus_e.req1_valid_i = 0; bus_e.req1_waddr_i = 0; bus_e.req1_wdata_i = 0;
        bus_e.raddr_a_i = 0; bus_e.raddr_b_i = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        step();
        n_cmp++;
        if ({bus.rf_we_o, bus.rf_waddr_o, bus.rf_wdata_o} !== 38'h0) begin
            n_mis++;
            $display("FAIL reset_wport: got we=%b a=%0d d=%h want 0/0/0", bus.rf_we_o, bus.rf_waddr_o, bus.rf_wdata_o);
        end
        n_cmp++;
        if ({bus.hazard_a_o, bus.hazard_b_o, bus.busy_o, bus.req0_ready_o, bus.req1_ready_o} !== 5'b0) begin
            n_mis++;
            $display("FAIL reset_flags: got ha=%b hb=%b busy=%b r0=%b r1=%b want all 0",
                     bus.hazard_a_o, bus.hazard_b_o, bus.busy_o, bus.req0_ready_o, bus.req1_ready_o);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        do_reset();
        bus.raddr_a_i = 5; bus.raddr_b_i = 6;
        bus.issue_valid_i = 1; bus.issue_waddr_i = 5;
        step();
        bus.issue_valid_i = 0;
        n_cmp++;
        if ({bus.hazard_a_o, bus.hazard_b_o, bus.busy_o} !== 3'b101) begin
            n_mis++;
            $display("FAIL basic_issue: got ha=%b hb=%b busy=%b want 1 0 1", bus.hazard_a_o, bus.hazard_b_o, bus.busy_o);
        end
        bus.req0_valid_i = 1; bus.req0_waddr_i = 5; bus.req0_wdata_i = 32'hDEADBEEF;
        #1;
        n_cmp++;
        if ({bus.req0_ready_o, bus.req1_ready_o, bus.hazard_a_o} !== 3'b101) begin
            n_mis++;
            $display("FAIL basic_grant: got r0=%b r1=%b ha=%b want 1 0 1", bus.req0_ready_o, bus.req1_ready_o, bus.hazard_a_o);
        end
        step();
        bus.req0_valid_i = 0;
        n_cmp++;
        if ({bus.rf_we_o, bus.rf_waddr_o, bus.rf_wdata_o, bus.hazard_a_o} !== {1'b1, 5'd5, 32'hDEADBEEF, 1'b1}) begin
            n_mis++;
            $display("FAIL basic_write: got we=%b a=%0d d=%h ha=%b want 1 5 deadbeef 1",
                     bus.rf_we_o, bus.rf_waddr_o, bus.rf_wdata_o, bus.hazard_a_o);
        end
        step();
        n_cmp++;
        if ({bus.rf_we_o, bus.hazard_a_o, bus.busy_o, bus.rf_waddr_o, bus.rf_wdata_o} !== {3'b000, 5'd5, 32'hDEADBEEF}) begin
            n_mis++;
            $display("FAIL basic_after: got we=%b ha=%b busy=%b a=%0d d=%h want 0 0 0 5 deadbeef",
                     bus.rf_we_o, bus.hazard_a_o, bus.busy_o, bus.rf_waddr_o, bus.rf_wdata_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] exp_a;
        do_reset();
        bus.req0_valid_i = 1; bus.req0_waddr_i = 1; bus.req0_wdata_i = 32'h100;
        bus.req1_valid_i = 1; bus.req1_waddr_i = 2; bus.req1_wdata_i = 32'h200;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++;
            if ({bus.req0_ready_o, bus.req1_ready_o} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                n_mis++;
                $display("FAIL rr_grant%0d: got r0=%b r1=%b want %s", i, bus.req0_ready_o, bus.req1_ready_o,
                         (i % 2 == 0) ? "req0" : "req1");
            end
            step();
            if (i == 3) begin
                bus.req0_valid_i = 0; bus.req1_valid_i = 0;
            end
            exp_a = (i % 2 == 0) ? 5'd1 : 5'd2;
            n_cmp++;
            if ({bus.rf_we_o, bus.rf_waddr_o, bus.rf_wdata_o} !== {1'b1, exp_a, (i % 2 == 0) ? 32'h100 : 32'h200}) begin
                n_mis++;
                $display("FAIL rr_write%0d: got we=%b a=%0d d=%h want 1 %0d", i, bus.rf_we_o, bus.rf_waddr_o, bus.rf_wdata_o, exp_a);
            end
        end
        step();
        n_cmp++;
        if ({bus.rf_we_o, bus.busy_o} !== 2'b00) begin
            n_mis++;
            $display("FAIL rr_drain: got we=%b busy=%b want 0 0", bus.rf_we_o, bus.busy_o);
        end
    endtask

    task automatic test_x0();
        do_reset();
        bus.issue_valid_i = 1; bus.issue_waddr_i = 6;
        bus.req0_valid_i = 1; bus.req0_waddr_i = 3; bus.req0_wdata_i = 32'hAAAA;
        step();
        bus.issue_valid_i = 0; bus.req0_valid_i = 0;
        bus.req1_valid_i = 1; bus.req1_waddr_i = 0; bus.req1_wdata_i = 32'h1234;
        #1;
        n_cmp++;
        if ({bus.req0_ready_o, bus.req1_ready_o} !== 2'b01) begin
            n_mis++;
            $display("FAIL x0_grant: got r0=%b r1=%b want 0 1", bus.req0_ready_o, bus.req1_ready_o);
        end
        step();
        bus.req1_valid_i = 0;
        n_cmp++;
        if ({bus.rf_we_o, bus.busy_o, bus.rf_waddr_o, bus.rf_wdata_o} !== {2'b01, 5'd3, 32'hAAAA}) begin
            n_mis++;
            $display("FAIL x0_drop: got we=%b busy=%b a=%0d d=%h want 0 1 3 0000aaaa",
                     bus.rf_we_o, bus.busy_o, bus.rf_waddr_o, bus.rf_wdata_o);
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        bus.raddr_a_i = 7;
        bus.issue_valid_i = 1; bus.issue_waddr_i = 7;
        step();
        bus.issue_valid_i = 0;
        bus.req0_valid_i = 1; bus.req0_waddr_i = 7; bus.req0_wdata_i = 32'h77;
        step();
        bus.req0_valid_i = 0;
        bus.issue_valid_i = 1; bus.issue_waddr_i = 7;
        n_cmp++;
        if ({bus.rf_we_o, bus.rf_waddr_o, bus.hazard_a_o} !== {1'b1, 5'd7, 1'b1}) begin
            n_mis++;
            $display("FAIL same_wcycle: got we=%b a=%0d ha=%b want 1 7 1", bus.rf_we_o, bus.rf_waddr_o, bus.hazard_a_o);
        end
        step();
        bus.issue_valid_i = 0;
        n_cmp++;
        if ({bus.rf_we_o, bus.hazard_a_o, bus.busy_o} !== 3'b011) begin
            n_mis++;
            $display("FAIL same_keep: got we=%b ha=%b busy=%b want 0 1 1", bus.rf_we_o, bus.hazard_a_o, bus.busy_o);
        end
    endtask

    task automatic test_rv32e();
        do_reset();
        bus_e.issue_valid_i = 1; bus_e.issue_waddr_i = 20;
        bus_e.raddr_a_i = 20; bus_e.raddr_b_i = 4;
        step();
        bus_e.issue_waddr_i = 4;
        n_cmp++;
        if ({bus_e.busy_o, bus_e.hazard_a_o} !== 2'b00) begin
            n_mis++;
            $display("FAIL e_issue20: got busy=%b ha=%b want 0 0", bus_e.busy_o, bus_e.hazard_a_o);
        end
        step();
        bus_e.issue_valid_i = 0;
        bus_e.req0_valid_i = 1; bus_e.req0_waddr_i = 20; bus_e.req0_wdata_i = 32'h2020;
        #1;
        n_cmp++;
        if (bus_e.req0_ready_o !== 1'b1) begin
            n_mis++;
            $display("FAIL e_grant: got r0=%b want 1", bus_e.req0_ready_o);
        end
        step();
        bus_e.req0_valid_i = 0;
        n_cmp++;
        if ({bus_e.rf_we_o, bus_e.hazard_a_o, bus_e.hazard_b_o, bus_e.busy_o} !== 4'b0011) begin
            n_mis++;
            $display("FAIL e_drop20: got we=%b ha=%b hb=%b busy=%b want 0 0 1 1",
                     bus_e.rf_we_o, bus_e.hazard_a_o, bus_e.hazard_b_o, bus_e.busy_o);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        bus.issue_valid_i = 1; bus.issue_waddr_i = 9;
        step();
        bus.issue_valid_i = 0;
        bus.req0_valid_i = 1; bus.req0_waddr_i = 9; bus.req0_wdata_i = 32'h99;
        step();
        bus.req0_valid_i = 0;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.rf_we_o, bus.busy_o} !== 2'b00) begin
            n_mis++;
            $display("FAIL mrst_async: got we=%b busy=%b want 0 0", bus.rf_we_o, bus.busy_o);
        end
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if ({bus.rf_we_o, bus.busy_o} !== 2'b00) begin
                n_mis++;
                $display("FAIL mrst_post%0d: got we=%b busy=%b want 0 0", i, bus.rf_we_o, bus.busy_o);
            end
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_basic();
        test_back_to_back();
        test_x0();
        test_same_cycle();
        test_rv32e();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
